// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and defaults for the 8-bit non-pipelined core.
// Consumed by fetch_sequencer (optional FETCH_PERF_CNT_EN) and pc_next_unit.
package cpu_pkg;

  localparam int PC_WIDTH_DEF    = 8;
  localparam int INSTR_WIDTH_DEF = 8;
  localparam int RESET_PC_DEF    = 0;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HOLD,
    DRAIN,
    HALTED
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_REDIR
  } pc_sel_t;

endpackage

// File: rtl/pc_next_unit.sv
// Combinational next-PC select: hold, increment (wraps at all-ones), or redirect.
module pc_next_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  pc_sel_t             sel,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PC_WIDTH-1:0] pc_next
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    pc_next = pc;
    case (sel)
      PC_INC:   pc_next = pc + PC_ONE;
      PC_REDIR: pc_next = redirect_pc;
      default:  pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage: owns the PC, runs a req/ack handshake to imem and
// hands instructions to decode. FETCH_PERF_CNT_EN adds fetch/stall counters.
//
// state  | meaning
// IDLE   | first cycle out of reset, launches fetch at pc
// REQ    | imem_req high, waiting for imem_ack on addr_q
// HOLD   | instr_out valid, waiting for decode_ready or redirect
// DRAIN  | redirected mid-request; discard the outstanding ack
// HALTED | fetch stopped until reset
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int RESET_PC    = RESET_PC_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  input  logic                   decode_ready,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  input  logic                   halt,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]            fetch_count,
  output logic [15:0]            stall_count,
`endif
  output logic                   halted
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);

  fetch_state_t state, state_d;
  pc_sel_t pc_sel;
  logic [PC_WIDTH-1:0] pc, pc_next, addr_q, addr_d, ipc_d;
  logic [INSTR_WIDTH-1:0] out_d;
  logic req_d, valid_d, halted_d;

  pc_next_unit #(.PC_WIDTH(PC_WIDTH)) u_pc_next (
    .sel         (pc_sel),
    .pc          (pc),
    .redirect_pc (redirect_pc),
    .pc_next     (pc_next)
  );

  assign imem_addr = addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC_V;
      addr_q      <= RESET_PC_V;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_next;
      addr_q      <= addr_d;
      imem_req    <= req_d;
      instr_valid <= valid_d;
      instr_out   <= out_d;
      instr_pc    <= ipc_d;
      halted      <= halted_d;
    end
  end

  always_comb begin
    state_d  = state;
    pc_sel   = PC_HOLD;
    addr_d   = addr_q;
    req_d    = imem_req;
    valid_d  = instr_valid;
    out_d    = instr_out;
    ipc_d    = instr_pc;
    halted_d = halted;
    case (state)
      IDLE: begin
        state_d = REQ;
        addr_d  = pc;
        req_d   = 1'b1;
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            // Returned word belongs to the abandoned path; reissue at target.
            pc_sel = PC_REDIR;
            addr_d = redirect_pc;
          end else begin
            out_d   = imem_rdata;
            ipc_d   = addr_q;
            valid_d = 1'b1;
            req_d   = 1'b0;
            state_d = HOLD;
          end
        end else if (redirect_valid) begin
          pc_sel  = PC_REDIR;
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_sel  = PC_REDIR;
          addr_d  = redirect_pc;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = REQ;
        end else if (decode_ready && halt) begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = HALTED;
        end else if (decode_ready) begin
          pc_sel  = PC_INC;
          addr_d  = pc_next;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (redirect_valid) pc_sel = PC_REDIR;
        if (imem_ack) begin
          addr_d  = pc_next;
          state_d = REQ;
        end
      end
      HALTED: begin
        req_d    = 1'b0;
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_inc, stall_inc;
  assign fetch_inc = (state == HOLD) && decode_ready && instr_valid && !redirect_valid;
  assign stall_inc = ((state == REQ) || (state == DRAIN)) && !imem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fetch_inc && (fetch_count != 16'hFFFF)) fetch_count <= fetch_count + 16'd1;
      if (stall_inc && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized
// run scored against a "next delivered PC" reference model.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic [7:0] instr_out;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       decode_ready = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       halt = 1'b0;
  logic       halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count, stall_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [256];
  int  mem_lat = 0;
  bit  rand_lat = 1'b0;
  int  wait_cnt = 0;
  int  cur_lat = 0;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .decode_ready   (decode_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count    (fetch_count),
    .stall_count    (stall_count),
`endif
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory: acks after cur_lat cycles of a held request.
  always @(negedge clk) begin
    if (imem_req === 1'b1) begin
      if (wait_cnt >= cur_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        wait_cnt   = 0;
        cur_lat    = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 8'($urandom);
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
      cur_lat  = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    decode_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    halt = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic redirect_once(input logic [7:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    cyc();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    n_cmp++;
    if ({imem_req, instr_valid, halted, instr_out, instr_pc, imem_addr} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_values: got req=%b val=%b hlt=%b out=%h pc=%h addr=%h expected all 0",
               imem_req, instr_valid, halted, instr_out, instr_pc, imem_addr);
    end
    mem_lat = 0;
    do_reset();
    cyc();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      n_err++;
      $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=00", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_latency();
    logic [7:0] exp_out [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int got = 0;
    int last_t = -1;
    mem_lat = 0;
    do_reset();
    decode_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      cyc();
      if (instr_valid === 1'b1) begin
        n_cmp++;
        if (instr_pc !== 8'(got) || instr_out !== exp_out[got]) begin
          n_err++;
          $display("FAIL zero_lat_data[%0d]: got pc=%h out=%h expected pc=%h out=%h",
                   got, instr_pc, instr_out, 8'(got), exp_out[got]);
        end
        if (got > 0) begin
          n_cmp++;
          if (c - last_t != 2) begin
            n_err++;
            $display("FAIL zero_lat_spacing: got %0d cycles expected 2", c - last_t);
          end
        end
        last_t = c;
        got++;
      end
    end
    decode_ready = 1'b0;
    n_cmp++;
    if (got != 4) begin
      n_err++;
      $display("FAIL zero_lat_count: got %0d instructions expected 4", got);
    end
  endtask

  task automatic test_delayed_ack_and_stall();
    int stalls = 0;
    logic [7:0] held_out, held_pc;
    mem_lat = 3;
    do_reset();
    cyc();
    for (int i = 0; i < 10; i++) begin
      if (!(imem_req === 1'b1 && imem_ack === 1'b0)) break;
      n_cmp++;
      if (imem_addr !== 8'h00) begin
        n_err++;
        $display("FAIL delayed_addr_stable: got %h expected 00", imem_addr);
      end
      stalls++;
      cyc();
    end
    n_cmp++;
    if (stalls != 3 || imem_ack !== 1'b1) begin
      n_err++;
      $display("FAIL delayed_stall_cycles: got %0d ack=%b expected 3 ack=1", stalls, imem_ack);
    end
    cyc();
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_out !== mem[0] || instr_pc !== 8'h00) begin
      n_err++;
      $display("FAIL delayed_valid: got val=%b out=%h pc=%h expected 1 %h 00",
               instr_valid, instr_out, instr_pc, mem[0]);
    end
    held_out = mem[0];
    held_pc = 8'h00;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_out !== held_out || instr_pc !== held_pc || imem_req !== 1'b0) begin
        n_err++;
        $display("FAIL hold_stable[%0d]: got val=%b out=%h pc=%h req=%b expected 1 %h %h 0",
                 i, instr_valid, instr_out, instr_pc, imem_req, held_out, held_pc);
      end
    end
    decode_ready = 1'b1;
    cyc();
    decode_ready = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h01 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_advance: got req=%b addr=%h val=%b expected 1 01 0",
               imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_redirect_drain();
    bit ok;
    bit saw80 = 1'b0;
    mem_lat = 0;
    do_reset();
    wait_valid(10, ok);
    mem_lat = 4;
    cyc();
    redirect_once(8'h05);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h05 || imem_ack !== 1'b0) begin
      n_err++;
      $display("FAIL drain_setup: got req=%b addr=%h ack=%b expected 1 05 0", imem_req, imem_addr, imem_ack);
    end
    mem_lat = 0;
    redirect_once(8'h80);
    for (int i = 0; i < 20; i++) begin
      if (instr_valid === 1'b1) break;
      if (imem_req === 1'b1 && imem_addr === 8'h80) saw80 = 1'b1;
      cyc();
    end
    n_cmp++;
    if (!saw80) begin
      n_err++;
      $display("FAIL drain_next_addr: got no request to 80 expected one");
    end
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'h80 || instr_out !== mem[8'h80]) begin
      n_err++;
      $display("FAIL drain_discard: got val=%b pc=%h out=%h expected 1 80 %h",
               instr_valid, instr_pc, instr_out, mem[8'h80]);
    end
  endtask

  task automatic test_redirect_priority_and_wrap();
    bit ok;
    mem_lat = 0;
    do_reset();
    wait_valid(10, ok);
    redirect_once(8'h10);
    wait_valid(10, ok);
    n_cmp++;
    if (!ok || instr_pc !== 8'h10) begin
      n_err++;
      $display("FAIL prio_setup: got ok=%b pc=%h expected 1 10", ok, instr_pc);
    end
    decode_ready = 1'b1;
    redirect_once(8'h40);
    decode_ready = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h40) begin
      n_err++;
      $display("FAIL prio_addr: got req=%b addr=%h expected 1 40", imem_req, imem_addr);
    end
    wait_valid(10, ok);
    n_cmp++;
    if (!ok || instr_pc !== 8'h40 || instr_out !== mem[8'h40]) begin
      n_err++;
      $display("FAIL prio_deliver: got ok=%b pc=%h out=%h expected 1 40 %h", ok, instr_pc, instr_out, mem[8'h40]);
    end
    redirect_once(8'hFF);
    wait_valid(10, ok);
    decode_ready = 1'b1;
    cyc();
    decode_ready = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      n_err++;
      $display("FAIL wrap_addr: got req=%b addr=%h expected 1 00", imem_req, imem_addr);
    end
    wait_valid(10, ok);
    n_cmp++;
    if (!ok || instr_pc !== 8'h00 || instr_out !== mem[0]) begin
      n_err++;
      $display("FAIL wrap_deliver: got ok=%b pc=%h out=%h expected 1 00 %h", ok, instr_pc, instr_out, mem[0]);
    end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    decode_ready = 1'b1;
    cyc();
    halt = 1'b0;
    decode_ready = 1'b0;
    n_cmp++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL halt_enter: got hlt=%b req=%b val=%b expected 1 0 0", halted, imem_req, instr_valid);
    end
    redirect_once(8'h33);
    repeat (5) cyc();
    n_cmp++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL halt_redirect_ignored: got hlt=%b req=%b val=%b expected 1 0 0", halted, imem_req, instr_valid);
    end
  endtask

  task automatic test_reset_in_drain();
    bit ok;
    mem_lat = 0;
    do_reset();
    wait_valid(10, ok);
    mem_lat = 6;
    cyc();
    decode_ready = 1'b1;
    cyc();
    decode_ready = 1'b0;
    cyc();
    redirect_once(8'h20);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h01 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_holds_addr: got req=%b addr=%h val=%b expected 1 01 0", imem_req, imem_addr, instr_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({imem_req, instr_valid, halted, instr_out, instr_pc, imem_addr} !== 27'd0) begin
      n_err++;
      $display("FAIL async_reset: got req=%b val=%b hlt=%b out=%h pc=%h addr=%h expected all 0",
               imem_req, instr_valid, halted, instr_out, instr_pc, imem_addr);
    end
    mem_lat = 0;
    cyc();
    cyc();
    reset = 1'b0;
    wait_valid(10, ok);
    n_cmp++;
    if (!ok || instr_pc !== 8'h00 || instr_out !== mem[0]) begin
      n_err++;
      $display("FAIL restart_pc: got ok=%b pc=%h out=%h expected 1 00 %h", ok, instr_pc, instr_out, mem[0]);
    end
  endtask

  // Reference: the next delivered instruction is at the last redirect target,
  // else one past the last consumed instruction; its word is mem[that pc].
  task automatic test_random();
    logic [7:0] exp_pc = 8'h00;
    logic [7:0] prev_addr = 8'h00;
    logic prev_req = 1'b0;
    logic prev_ack = 1'b0;
    int delivered = 0;
    rand_lat = 1'b1;
    do_reset();
    cyc();
    for (int c = 0; c < 400; c++) begin
      if (prev_req === 1'b1 && prev_ack === 1'b0) begin
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          n_err++;
          $display("FAIL rand_handshake@%0d: got req=%b addr=%h expected 1 %h", c, imem_req, imem_addr, prev_addr);
        end
      end
      if (instr_valid === 1'b1) begin
        n_cmp++;
        if (instr_pc !== exp_pc || instr_out !== mem[exp_pc]) begin
          n_err++;
          $display("FAIL rand_deliver@%0d: got pc=%h out=%h expected pc=%h out=%h",
                   c, instr_pc, instr_out, exp_pc, mem[exp_pc]);
        end
      end
      prev_req = imem_req;
      prev_ack = imem_ack;
      prev_addr = imem_addr;
      decode_ready = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc = 8'($urandom);
      if (redirect_valid) exp_pc = redirect_pc;
      else if (instr_valid === 1'b1 && decode_ready) begin
        exp_pc = exp_pc + 8'd1;
        delivered++;
      end
      cyc();
    end
    decode_ready = 1'b0;
    redirect_valid = 1'b0;
    rand_lat = 1'b0;
    n_cmp++;
    if (delivered < 20) begin
      n_err++;
      $display("FAIL rand_progress: got %0d consumed expected at least 20", delivered);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    mem[3] = 8'h44;
    mem[5] = 8'h55;
    mem[8'h80] = 8'hA8;
    test_reset();
    test_zero_latency();
    test_delayed_ack_and_stall();
    test_redirect_drain();
    test_redirect_priority_and_wrap();
    test_halt();
    test_reset_in_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 expected earlier finish");
    $fatal(1, "timeout");
  end

endmodule
